// File: rtl/conv_gemm.sv
// GEMM stage after im2col: out[p][oc] = sum_k im2col[p][k]*w[oc][k], one element read per cycle.
// Optional CONV_GEMM_RELU_EN clamps negative results to zero at write time; timing is unaffected.
module conv_gemm #(
  parameter int IMG_C       = 1,
  parameter int IMG_W       = 8,
  parameter int IMG_H       = 8,
  parameter int FILTER_SIZE = 3,
  parameter int OUT_C       = 2,
  parameter int DATA_WIDTH  = 8,
  parameter int OUT_WIDTH   = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] IM2COL_BASE = ADDR_WIDTH'(16'h2000),
  parameter logic [ADDR_WIDTH-1:0] WEIGHT_BASE = ADDR_WIDTH'(16'h3000),
  parameter logic [ADDR_WIDTH-1:0] OUT_BASE    = ADDR_WIDTH'(16'h4000)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] data_rd,
  output logic [ADDR_WIDTH-1:0] addr_rd,
  output logic [ADDR_WIDTH-1:0] addr_wr,
  output logic [OUT_WIDTH-1:0]  data_wr,
  output logic                  mem_wr_en,
  output logic                  done
);
  localparam int K  = FILTER_SIZE * FILTER_SIZE * IMG_C;
  localparam int N  = IMG_W * IMG_H;
  localparam int PW = $clog2(N + 1);
  localparam int KW = $clog2(K + 1);
  localparam int OW = $clog2(OUT_C + 1);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_MAC, S_WRITE, S_DONE} state_t;

  state_t                        state;
  logic [PW-1:0]                 p;
  logic [OW-1:0]                 oc;
  logic [KW-1:0]                 cnt;
  logic signed [OUT_WIDTH-1:0]   acc;
  logic signed [DATA_WIDTH-1:0]  row_buf [K];

  logic signed [2*DATA_WIDTH-1:0] prod;
  logic signed [OUT_WIDTH-1:0]    acc_nxt;
  logic signed [OUT_WIDTH-1:0]    wr_val;
  logic [ADDR_WIDTH-1:0]          row_base, w_base, cnt_a1, out_addr;

  // row_buf is a rotating shift register: element 0 is always at the head during MAC,
  // and K rotations restore the original order so the row is reused for every oc.
  assign prod    = $signed(data_rd) * row_buf[0];
  assign acc_nxt = acc + {{(OUT_WIDTH-2*DATA_WIDTH){prod[2*DATA_WIDTH-1]}}, prod};
`ifdef CONV_GEMM_RELU_EN
  assign wr_val  = acc_nxt[OUT_WIDTH-1] ? '0 : acc_nxt;
`else
  assign wr_val  = acc_nxt;
`endif

  assign row_base = IM2COL_BASE + ADDR_WIDTH'(p) * ADDR_WIDTH'(K);
  assign w_base   = WEIGHT_BASE + ADDR_WIDTH'(oc) * ADDR_WIDTH'(K);
  assign cnt_a1   = ADDR_WIDTH'(cnt) + ADDR_WIDTH'(1);
  assign out_addr = OUT_BASE + ADDR_WIDTH'(p) * ADDR_WIDTH'(OUT_C) + ADDR_WIDTH'(oc);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      p         <= '0;
      oc        <= '0;
      cnt       <= '0;
      acc       <= '0;
      for (int j = 0; j < K; j++) row_buf[j] <= '0;
      addr_rd   <= IM2COL_BASE;
      addr_wr   <= OUT_BASE;
      data_wr   <= '0;
      mem_wr_en <= 1'b0;
      done      <= 1'b0;
    end else begin
      mem_wr_en <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            p       <= '0;
            oc      <= '0;
            cnt     <= '0;
            addr_rd <= IM2COL_BASE;
            state   <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (cnt != '0) begin
            for (int j = 0; j < K - 1; j++) row_buf[j] <= row_buf[j+1];
            row_buf[K-1] <= $signed(data_rd);
          end
          if (cnt == KW'(K)) begin
            cnt     <= '0;
            acc     <= '0;
            addr_rd <= w_base;
            state   <= S_MAC;
          end else begin
            cnt <= cnt + 1'b1;
            if (cnt != KW'(K - 1)) addr_rd <= row_base + cnt_a1;
          end
        end
        S_MAC: begin
          if (cnt != '0) begin
            acc <= acc_nxt;
            for (int j = 0; j < K - 1; j++) row_buf[j] <= row_buf[j+1];
            row_buf[K-1] <= row_buf[0];
          end
          if (cnt == KW'(K)) begin
            cnt       <= '0;
            mem_wr_en <= 1'b1;
            addr_wr   <= out_addr;
            data_wr   <= wr_val;
            state     <= S_WRITE;
          end else begin
            cnt <= cnt + 1'b1;
            if (cnt != KW'(K - 1)) addr_rd <= w_base + cnt_a1;
          end
        end
        S_WRITE: begin
          cnt <= '0;
          acc <= '0;
          if (oc != OW'(OUT_C - 1)) begin
            oc      <= oc + 1'b1;
            addr_rd <= w_base + ADDR_WIDTH'(K);
            state   <= S_MAC;
          end else if (p != PW'(N - 1)) begin
            p       <= p + 1'b1;
            oc      <= '0;
            addr_rd <= row_base + ADDR_WIDTH'(K);
            state   <= S_FETCH;
          end else begin
            state <= S_DONE;
          end
        end
        S_DONE:  done  <= 1'b1;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_conv_gemm.sv
// Bench for conv_gemm: memory model, table vectors, random data against an arithmetic reference.
module tb_conv_gemm;
  localparam int K     = 9;
  localparam int N     = 64;
  localparam int OC    = 2;
  localparam int PER   = (K + 1) + OC * (K + 2);
  localparam int TOTAL = N * PER;
  localparam int DONE_EDGES = TOTAL + 1;

  logic        clk, rst_n, start;
  logic [7:0]  data_rd;
  logic [31:0] addr_rd, addr_wr, data_wr;
  logic        mem_wr_en, done;

  conv_gemm dut (
    .clk(clk), .rst_n(rst_n), .start(start), .data_rd(data_rd),
    .addr_rd(addr_rd), .addr_wr(addr_wr), .data_wr(data_wr),
    .mem_wr_en(mem_wr_en), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] im_mem [N*K];
  logic [7:0] w_mem  [OC*K];
  int wr_addr_q[$];
  int wr_dat_q[$];
  int total, bad;

  function automatic logic [7:0] rd_lookup(logic [31:0] a);
    int i;
    i = int'(a);
    if (i >= 'h2000 && i < 'h2000 + N*K) return im_mem[i - 'h2000];
    if (i >= 'h3000 && i < 'h3000 + OC*K) return w_mem[i - 'h3000];
    return 8'h00;
  endfunction

  always @(posedge clk) data_rd <= rd_lookup(addr_rd);

  always @(negedge clk)
    if (rst_n && mem_wr_en) begin
      wr_addr_q.push_back(int'(addr_wr));
      wr_dat_q.push_back(int'(data_wr));
    end

  function automatic int relu(int x);
`ifdef CONV_GEMM_RELU_EN
    return (x < 0) ? 0 : x;
`else
    return x;
`endif
  endfunction

  function automatic int ref_out(int p, int oc);
    int s;
    byte a, b;
    s = 0;
    for (int k = 0; k < K; k++) begin
      a = byte'(im_mem[p*K + k]);
      b = byte'(w_mem[oc*K + k]);
      s = s + int'(a) * int'(b);
    end
    return relu(s);
  endfunction

  // Expected read address for cycle c after the start edge; valid=0 on drain/write cycles.
  task automatic exp_addr(input int c, output bit valid, output int a);
    int p, r, oc, j;
    p = c / PER;
    r = c % PER;
    valid = 1'b0;
    a = 0;
    if (r < K) begin
      valid = 1'b1;
      a = 'h2000 + p*K + r;
    end else if (r > K) begin
      oc = (r - (K + 1)) / (K + 2);
      j  = (r - (K + 1)) % (K + 2);
      if (j < K) begin
        valid = 1'b1;
        a = 'h3000 + oc*K + j;
      end
    end
  endtask

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    start = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic fill_const(input logic [7:0] im, input logic [7:0] w0, input logic [7:0] w1);
    for (int i = 0; i < N*K; i++) im_mem[i] = im;
    for (int k = 0; k < K; k++) begin
      w_mem[k]     = w0;
      w_mem[K + k] = w1;
    end
  endtask

  task automatic run_job(input bit chk_addr, output int edges);
    int c, addr_bad, ea;
    bit ev;
    wr_addr_q.delete();
    wr_dat_q.delete();
    addr_bad = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    c = 0;
    edges = -1;
    forever begin
      @(negedge clk);
      if (chk_addr && c < TOTAL) begin
        exp_addr(c, ev, ea);
        if (ev && int'(addr_rd) != ea) addr_bad++;
      end
      if (done) begin
        edges = c;
        break;
      end
      if (c >= 3 * TOTAL) break;
      @(posedge clk);
      c++;
    end
    if (chk_addr) check("addr_rd_seq_mismatches", addr_bad, 0);
  endtask

  task automatic verify_job(input string tag, input int edges, input bit use_tab,
                            input int e0, input int e1);
    int abad, dbad, ex;
    check({tag, "_done_edge"}, edges, DONE_EDGES);
    check({tag, "_write_count"}, wr_addr_q.size(), N*OC);
    abad = 0;
    dbad = 0;
    for (int i = 0; i < wr_addr_q.size() && i < N*OC; i++) begin
      if (wr_addr_q[i] != 'h4000 + i) abad++;
      if (use_tab) ex = (i % OC == 0) ? e0 : e1;
      else         ex = ref_out(i / OC, i % OC);
      if (wr_dat_q[i] != ex) dbad++;
    end
    check({tag, "_addr_wr_errors"}, abad, 0);
    check({tag, "_data_wr_errors"}, dbad, 0);
  endtask

  typedef struct {
    logic [7:0] im;
    logic [7:0] w0;
    logic [7:0] w1;
    int         e0;
    int         e1;
  } vec_t;

  initial begin
    vec_t tab[4];
    int edges, n_wr, n_addr, n_done, cyc, a_hold;
    bit hit;

    total = 0;
    bad   = 0;
    start = 1'b0;
    rst_n = 1'b0;
    fill_const(8'h00, 8'h00, 8'h00);

    tab[0] = '{8'h01, 8'h01, 8'h01, 9, 9};
    tab[1] = '{8'h80, 8'h80, 8'h80, 147456, 147456};
    tab[2] = '{8'h80, 8'h7F, 8'h7F, relu(-146304), relu(-146304)};
    tab[3] = '{8'h01, 8'h01, 8'hFF, 9, relu(-9)};

    // Reset values while reset is held.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_addr_rd", addr_rd, 'h2000);
    check("rst_addr_wr", addr_wr, 'h4000);
    check("rst_data_wr", data_wr, 0);
    check("rst_mem_wr_en", mem_wr_en, 0);
    check("rst_done", done, 0);
    rst_n = 1'b1;

    // Idle with start low.
    n_wr = 0; n_addr = 0; n_done = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (mem_wr_en) n_wr++;
      if (addr_rd != 32'h2000) n_addr++;
      if (done) n_done++;
    end
    check("idle_writes", n_wr, 0);
    check("idle_addr_rd_moves", n_addr, 0);
    check("idle_done_cycles", n_done, 0);

    for (int t = 0; t < 4; t++) begin
      do_reset();
      fill_const(tab[t].im, tab[t].w0, tab[t].w1);
      run_job(1'b0, edges);
      verify_job($sformatf("vec%0d", t), edges, 1'b1, tab[t].e0, tab[t].e1);
    end

    // Indexing pattern with cycle-exact read-address check.
    do_reset();
    for (int p = 0; p < N; p++)
      for (int k = 0; k < K; k++) im_mem[p*K + k] = 8'(p + k);
    for (int k = 0; k < K; k++) begin
      w_mem[k]     = 8'(k + 1);
      w_mem[K + k] = 8'd1;
    end
    run_job(1'b1, edges);
    verify_job("index", edges, 1'b0, 0, 0);

    for (int r = 0; r < 2; r++) begin
      do_reset();
      for (int i = 0; i < N*K; i++) im_mem[i] = 8'($urandom_range(0, 255));
      for (int i = 0; i < OC*K; i++) w_mem[i] = 8'($urandom_range(0, 255));
      run_job(1'b0, edges);
      verify_job($sformatf("rand%0d", r), edges, 1'b0, 0, 0);
    end

    // Terminal state: start toggling must not restart anything.
    n_wr = wr_addr_q.size();
    a_hold = int'(addr_rd);
    n_done = 0; n_addr = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      start = ~start;
      if (!done) n_done++;
      if (int'(addr_rd) != a_hold) n_addr++;
    end
    check("term_done_drops", n_done, 0);
    check("term_extra_writes", wr_addr_q.size() - n_wr, 0);
    check("term_addr_rd_moves", n_addr, 0);

    // Reset asserted in the middle of a WRITE cycle.
    do_reset();
    fill_const(8'h01, 8'h01, 8'h01);
    wr_addr_q.delete();
    wr_dat_q.delete();
    @(negedge clk);
    start = 1'b1;
    hit = 1'b0;
    cyc = 0;
    while (!hit && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (mem_wr_en && wr_addr_q.size() >= 5) hit = 1'b1;
    end
    check("midrst_reached_write", hit, 1);
    #2;
    start = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_addr_rd", addr_rd, 'h2000);
    check("midrst_addr_wr", addr_wr, 'h4000);
    check("midrst_data_wr", data_wr, 0);
    check("midrst_mem_wr_en", mem_wr_en, 0);
    check("midrst_done", done, 0);
    n_wr = wr_addr_q.size();
    repeat (3) @(negedge clk);
    check("midrst_no_write", wr_addr_q.size() - n_wr, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("midrst_idle_addr_rd", addr_rd, 'h2000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/conv_gemm.md
Name: conv_gemm

Overview:
- Downstream consumer of the im2col stage.
- Starts when im2col asserts done. Reads the im2col matrix and a weight matrix from the shared memory, computes one output per (pixel, output channel) with a sequential signed multiply-accumulate, and writes results back to memory.
- Completes the conv layer as im2col × weightsᵀ.

Parameters:
- IMG_C, 1, input channels.
- IMG_W, 8, image width.
- IMG_H, 8, image height.
- FILTER_SIZE, 3, filter edge.
- OUT_C, 2, output channels (filters).
- DATA_WIDTH, 8, signed input/weight element width.
- OUT_WIDTH, 32, signed accumulator/output width.
- ADDR_WIDTH, 32, address width.
- IM2COL_BASE, 16'h2000, base of the im2col matrix, row-major, N rows × K elements.
- WEIGHT_BASE, 16'h3000, base of the weights, row-major, OUT_C rows × K elements.
- OUT_BASE, 16'h4000, base of the output, address OUT_BASE + p*OUT_C + oc.
- Derived: K = FILTER_SIZE*FILTER_SIZE*IMG_C; N = IMG_W*IMG_H.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  level; tied to im2col done.
- data_rd  input  DATA_WIDTH  memory read data, valid the cycle after addr_rd.
- addr_rd  output  ADDR_WIDTH  memory read address, one element per address.
- addr_wr  output  ADDR_WIDTH  memory write address.
- data_wr  output  OUT_WIDTH  memory write data.
- mem_wr_en  output  1  write strobe; one write per cycle it is high.
- done  output  1  high once all N*OUT_C outputs are written.

Behaviour:
- Reset is asynchronous, active-low. Reset values:
  - addr_rd = IM2COL_BASE, addr_wr = OUT_BASE, data_wr = 0, mem_wr_en = 0, done = 0.
  - All counters, the accumulator and the row buffer are cleared. State = IDLE.
- Reset asserted mid-operation aborts immediately to these values, with no partial write.
- IDLE:
  - Stays while start = 0.
  - start = 1 sampled at a clock edge: p = 0, oc = 0, go to FETCH.
- FETCH (K+1 cycles):
  - Cycle i, for i in 0..K-1, drives addr_rd = IM2COL_BASE + p*K + i.
  - The data for element i-1 is captured into row_buf[i-1].
  - Cycle K is a drain cycle that captures row_buf[K-1].
  - Then acc = 0, go to MAC.
- MAC (K+1 cycles per oc):
  - Cycle i drives addr_rd = WEIGHT_BASE + oc*K + i.
  - The returned weight for element i-1 is multiplied with row_buf[i-1] and added: acc += sext(w)*sext(x).
  - The product is a full 2*DATA_WIDTH signed value, sign-extended to OUT_WIDTH. The sum wraps modulo 2^OUT_WIDTH; no saturation.
  - The drain cycle adds the last product, then go to WRITE.
- WRITE (1 cycle):
  - mem_wr_en = 1, addr_wr = OUT_BASE + p*OUT_C + oc, data_wr = acc.
  - If oc < OUT_C-1: oc++, acc = 0, back to MAC. The row is not refetched.
  - Else if p < N-1: p++, oc = 0, go to FETCH.
  - Else go to DONE.
- DONE:
  - done = 1, mem_wr_en = 0.
  - Terminal state; only reset leaves it. start is ignored.
- mem_wr_en is high only in WRITE cycles. addr_wr/data_wr hold their last values otherwise.
- Latency:
  - Per pixel: (K+1) + OUT_C*(K+2) cycles.
  - done rises N*((K+1)+OUT_C*(K+2)) + 1 edges after the edge that samples start.
  - Defaults give 2049 edges.
- Boundary cases:
  - K = 1 (FILTER_SIZE=1, IMG_C=1) gives FETCH = 2 cycles and MAC = 2 cycles.
  - OUT_C = 1 skips the oc loop.
  - Counters are wide enough for N, K and OUT_C without wrap.

Optional Feature:
- Macro: CONV_GEMM_RELU_EN.
- Defined: in WRITE, data_wr = (acc[OUT_WIDTH-1] ? 0 : acc). Negative results are written as 0. Timing is unchanged.
- Not defined: the raw acc is written.

Test Plan:
- Reset/idle:
  - Assert rst_n = 0 mid-run -> all outputs take their reset values in the same cycle.
  - Hold start = 0 for 100 cycles -> no writes, addr_rd = 16'h2000, done = 0.
- Unit data:
  - Stimulus: all im2col = 1, all weights = 1, defaults.
  - Expect: 128 writes, each data_wr = 9, addresses 16'h4000..16'h407F in order, done at edge 2049.
- Signed extreme:
  - Stimulus: im2col = 8'h80 (-128), weights = 8'h80.
  - Expect: every output = 147456 (32'h00024000).
  - Stimulus: weights = 8'h7F, im2col = 8'h80.
  - Expect: -146304 (32'hFFFDC480).
- Per-channel mix:
  - Stimulus: im2col = 1, weight row oc0 = 1, row oc1 = -1 (8'hFF).
  - Expect: alternating writes 9 and -9 (32'hFFFFFFF7).
  - With CONV_GEMM_RELU_EN: alternating 9 and 0.
- Indexing:
  - Stimulus: im2col[p][k] = p[7:0]+k, weights oc0 = k+1, oc1 = 1.
  - Expect: each output matches a reference model; addr_rd sequence matches the FETCH/MAC formulas exactly, cycle by cycle.
- Terminal:
  - After done, toggle start for 50 cycles -> done stays 1, no further writes, state unchanged until rst_n.
